// File: rtl/iterative_divider_pkg.sv
// divider_pkg: operation/state types and constants shared by the iterative divider files
package divider_pkg;
  localparam int DIV_OP_W = 2;
  typedef enum logic [DIV_OP_W-1:0] {DIV, DIVU, REM, REMU} div_op_t;
  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} div_state_t;
endpackage

// File: rtl/iterative_divider_if.sv
// iterative_divider_if: request/response bundle between the core and the divider
// wordOp exists only when DIV_WORD_EN is defined.
interface iterative_divider_if #(parameter int N = 64);
  import divider_pkg::*;
  logic start, busy, done;
  div_op_t op;
  logic [N-1:0] dividend, divisor, result;
`ifdef DIV_WORD_EN
  logic wordOp;
  modport master(output start, op, wordOp, dividend, divisor, input busy, done, result);
  modport slave(input start, op, wordOp, dividend, divisor, output busy, done, result);
`else
  modport master(output start, op, dividend, divisor, input busy, done, result);
  modport slave(input start, op, dividend, divisor, output busy, done, result);
`endif
endinterface

// File: rtl/iterative_divider_special_detect.sv
// div_special_detect: flags divide-by-zero and signed overflow and supplies their results
module div_special_detect import divider_pkg::*; #(
  parameter int N = 64
) (
  input  div_op_t        op,
  input  logic           word,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           hit,
  output logic [N-1:0]   res
);
  logic zero, ovf;
  logic [N-1:0] minv;
  always_comb begin
    minv = word ? {N{1'b1}} << 31 : {1'b1, {(N-1){1'b0}}};
    zero = b == '0;
    ovf = ~op[0] & (a == minv) & (&b);
    hit = zero | ovf;
    res = zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);
  end
endmodule

// File: rtl/iterative_divider.sv
// iterative_divider: restoring DIV/DIVU/REM/REMU, one quotient bit per cycle
// Define DIV_WORD_EN to add the 32-bit W variants selected by wordOp.
module iterative_divider import divider_pkg::*; #(
  parameter int N = 64
) (
  input logic clk,
  input logic resetN,
  iterative_divider_if.slave bus
);
  localparam int CW = $clog2(N);
  div_state_t state, state_n;
  div_op_t op_q;
  logic [CW-1:0] cnt;
  logic [N-1:0] rem, quo, dvs, result, a_ext, b_ext, a_mag, b_mag, a_init, sp_res, sp_fit, raw, fin, rem_n, quo_n;
  logic [N:0] sh, diff;
  logic word, sgn, a_neg, b_neg, neg_q, rneg_q, hit, ge, take;
`ifdef DIV_WORD_EN
  logic word_q;
  function automatic logic [N-1:0] ext32(input logic [N-1:0] x, input logic s);
    return {{(N-32){s & x[31]}}, x[31:0]};
  endfunction
  assign word = bus.wordOp;
  assign a_ext = word ? ext32(bus.dividend, sgn) : bus.dividend;
  assign b_ext = word ? ext32(bus.divisor, sgn) : bus.divisor;
  assign sp_fit = word ? ext32(sp_res, 1'b1) : sp_res;
  assign fin = word_q ? ext32(raw, 1'b1) : raw;
`else
  assign word = 1'b0;
  assign a_ext = bus.dividend;
  assign b_ext = bus.divisor;
  assign sp_fit = sp_res;
  assign fin = raw;
`endif
  assign sgn = ~bus.op[0];
  assign a_neg = sgn & a_ext[N-1];
  assign b_neg = sgn & b_ext[N-1];
  assign a_mag = a_neg ? -a_ext : a_ext;
  assign b_mag = b_neg ? -b_ext : b_ext;
  // word operands sit in the top half so W shifts consume exactly their 32 bits
  assign a_init = word ? a_mag << (N-32) : a_mag;
  assign take = state == IDLE && bus.start;
  assign sh = {rem, quo[N-1]};
  assign diff = sh - {1'b0, dvs};
  assign ge = ~diff[N];
  assign rem_n = ge ? diff[N-1:0] : sh[N-1:0];
  assign quo_n = {quo[N-2:0], ge};
  assign raw = op_q[1] ? (rneg_q ? -rem : rem) : (neg_q ? -quo : quo);
  assign bus.result = result;
  div_special_detect #(.N(N)) u_special (
    .op(bus.op), .word(word), .a(a_ext), .b(b_ext), .hit(hit), .res(sp_res)
  );
  always_ff @(posedge clk) state <= !resetN ? IDLE : state_n;
  always_comb
    state_n = state == IDLE ? (bus.start ? (hit ? DONE : CALC) : IDLE) :
              state == CALC ? (cnt == '0 ? FIXUP : CALC) :
              state == FIXUP ? DONE : IDLE;
  always_comb begin
    bus.busy = state != IDLE;
    bus.done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (!resetN) begin
      op_q <= DIV;
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      neg_q <= 1'b0;
      rneg_q <= 1'b0;
      result <= '0;
`ifdef DIV_WORD_EN
      word_q <= 1'b0;
`endif
    end else begin
      if (take) begin
        op_q <= bus.op;
        cnt <= word ? CW'(31) : CW'(N-1);
        rem <= '0;
        quo <= a_init;
        dvs <= b_mag;
        neg_q <= a_neg ^ b_neg;
        rneg_q <= a_neg;
`ifdef DIV_WORD_EN
        word_q <= word;
`endif
        if (hit) result <= sp_fit;
      end
      if (state == CALC) begin
        rem <= rem_n;
        quo <= quo_n;
        if (cnt != '0) cnt <= cnt - 1'b1;
      end
      if (state == FIXUP) result <= fin;
    end
  end
endmodule
